axis_dense_layer: RTL and testbench

- Parametrised, fully streaming fixed-point dense (fully-connected) layer with AXI-Stream input and output.
- Packs LANES signed elements per AXI beat.
- Holds runtime-loadable weights and biases, saturates results, optionally applies ReLU, and enforces TLAST framing.
- Drop-in compute stage between AXI-Stream DMA and downstream inference layers; generalises the fixed 16-in/16-out, 2-lane layer.

---
 rtl/axis_dense_layer_if.sv | 21 ++
 rtl/axis_dense_layer.sv | 203 ++++++++++++++++++++
 tb/tb_axis_dense_layer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_dense_layer_if.sv
// rtl/axis_dense_layer_if.sv - AXI-Stream style beat channel used by the dense layer
//
// Purpose: one stream channel carrying LANES packed signed elements per beat.
// Signals:
//   tdata  [LANES*DATA_W] - packed beat, lane k at bits [k*DATA_W +: DATA_W]
//   tlast                 - last beat of a frame
//   tvalid                - producer has a beat
//   tready                - consumer accepts the beat
// Modports: master drives tdata/tlast/tvalid, slave drives tready.
interface axis_dense_layer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2
);
  logic [LANES*DATA_W-1:0] tdata;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_dense_layer.sv
// rtl/axis_dense_layer.sv - streaming fixed-point dense layer with stream in/out
//
// Purpose: collects one frame of N_IN signed elements, computes
//   y[o] = sat((B[o] << FRAC_W + sum_i x[i]*W[o][i]) >>> FRAC_W), optional ReLU,
//   and streams N_OUT results out, LANES elements per beat.
// Ports:
//   ap_clk, ap_rst     - clock, asynchronous active-high reset
//   in_r  (slave)      - input frame stream
//   out_r (master)     - output frame stream
//   w_en/w_addr/w_data - parameter write (W[o][i] at o*N_IN+i, B[o] at N_OUT*N_IN+o)
//   w_ready            - a write is accepted this cycle
//   err_tlast          - sticky input framing error
//   busy               - frame in flight
module axis_dense_layer #(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 16,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 2,
  parameter int RELU   = 0,
  localparam int AW    = $clog2(N_OUT*N_IN+N_OUT)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  axis_dense_layer_if.slave        in_r,
  axis_dense_layer_if.master       out_r,
  input  logic                     w_en,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     w_ready,
  output logic                     err_tlast,
  output logic                     busy
);
  localparam int IN_BEATS  = N_IN / LANES;
  localparam int OUT_BEATS = N_OUT / LANES;
  localparam int IB_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OB_W      = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int XI_W      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int MC_W      = $clog2(N_IN + 1);
  localparam int P_W       = 2 * DATA_W;
  localparam int ACC_W     = 2 * DATA_W + $clog2(N_IN) + 1;

  localparam logic [IB_W-1:0] IN_LAST  = IB_W'(IN_BEATS - 1);
  localparam logic [OB_W-1:0] OUT_LAST = OB_W'(OUT_BEATS - 1);
  localparam logic [MC_W-1:0] MAC_LAST = MC_W'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t                    state;
  logic [IB_W-1:0]           in_beat;
  logic [OB_W-1:0]           out_beat;
  logic [MC_W-1:0]           mac_cnt;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      out_last_q;
  logic [LANES*DATA_W-1:0]   out_data_q;
  logic                      err_q;

  logic signed [DATA_W-1:0]  w_mem [N_OUT][N_IN];
  logic signed [DATA_W-1:0]  b_mem [N_OUT];
  logic signed [DATA_W-1:0]  x_mem [N_IN];
  logic signed [ACC_W-1:0]   acc   [N_OUT];
  logic signed [P_W-1:0]     prod  [N_OUT];
  logic signed [DATA_W-1:0]  y     [N_OUT];

  logic                      in_fire;
  logic                      in_close;
  logic                      out_fire;
  logic [XI_W-1:0]           mac_idx;
  logic [OB_W-1:0]           beat_sel;
  logic [LANES*DATA_W-1:0]   beat_data;

  assign in_fire   = in_r.tvalid & in_ready_q;
  // A frame closes on the last beat or on any beat carrying tlast.
  assign in_close  = in_fire & (in_r.tlast | (in_beat == IN_LAST));
  assign out_fire  = out_valid_q & out_r.tready;
  assign mac_idx   = mac_cnt[XI_W-1:0];

  assign in_r.tready  = in_ready_q;
  assign out_r.tvalid = out_valid_q;
  assign out_r.tlast  = out_last_q;
  assign out_r.tdata  = out_data_q;
  assign err_tlast    = err_q;
  assign w_ready      = (state == S_LOAD) && (in_beat == '0);
  assign busy         = (state != S_LOAD) || (in_beat != '0);

  function automatic logic signed [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0]  r;
    logic signed [DATA_W-1:0] q;
    r = a >>> FRAC_W;
    if (r > SAT_MAX)      q = SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN) q = SAT_MIN[DATA_W-1:0];
    else                  q = r[DATA_W-1:0];
    if (RELU != 0 && q[DATA_W-1]) q = '0;
    return q;
  endfunction

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      prod[o] = P_W'(x_mem[mac_idx]) * P_W'(w_mem[o][mac_idx]);
      y[o]    = quant(acc[o]);
    end
  end

  // Beat to present next: beat 0 when leaving COMPUTE, otherwise the following beat.
  assign beat_sel = (state == S_DRAIN) ? out_beat + 1'b1 : '0;

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < OUT_BEATS; b++)
      for (int k = 0; k < LANES; k++)
        if (beat_sel == OB_W'(b)) beat_data[k*DATA_W +: DATA_W] = y[b*LANES+k];
  end

  // Parameter storage is deliberately not reset.
  always_ff @(posedge ap_clk) begin
    if (w_en && w_ready) begin
      for (int o = 0; o < N_OUT; o++) begin
        for (int i = 0; i < N_IN; i++)
          if (w_addr == AW'(o*N_IN + i)) w_mem[o][i] <= w_data;
        if (w_addr == AW'(N_OUT*N_IN + o)) b_mem[o] <= w_data;
      end
    end
  end

  // Datapath: input capture with zero-fill on early tlast, then the MAC sweep.
  always_ff @(posedge ap_clk) begin
    if (state == S_LOAD && in_fire) begin
      for (int i = 0; i < N_IN; i++) begin
        if (IB_W'(i / LANES) == in_beat)
          x_mem[i] <= in_r.tdata[(i % LANES)*DATA_W +: DATA_W];
        else if (in_r.tlast && IB_W'(i / LANES) > in_beat)
          x_mem[i] <= '0;
      end
      if (in_close)
        for (int o = 0; o < N_OUT; o++) acc[o] <= ACC_W'(b_mem[o]) <<< FRAC_W;
    end else if (state == S_COMPUTE && mac_cnt != MAC_LAST) begin
      for (int o = 0; o < N_OUT; o++) acc[o] <= acc[o] + ACC_W'(prod[o]);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= S_LOAD;
      in_beat     <= '0;
      out_beat    <= '0;
      mac_cnt     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            // Flags both an early tlast and a missing tlast on the final beat.
            if (in_r.tlast != (in_beat == IN_LAST)) err_q <= 1'b1;
            if (in_close) begin
              state      <= S_COMPUTE;
              in_beat    <= '0;
              mac_cnt    <= '0;
              in_ready_q <= 1'b0;
            end else begin
              in_beat <= in_beat + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          // The extra cycle at MAC_LAST lets the final accumulate settle before quantising.
          if (mac_cnt == MAC_LAST) begin
            state       <= S_DRAIN;
            out_beat    <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (OUT_LAST == '0);
            out_data_q  <= beat_data;
          end else begin
            mac_cnt <= mac_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (out_beat == OUT_LAST) begin
              state       <= S_LOAD;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              in_ready_q  <= 1'b1;
            end else begin
              out_beat   <= out_beat + 1'b1;
              out_data_q <= beat_data;
              out_last_q <= ((out_beat + 1'b1) == OUT_LAST);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_dense_layer.sv
// tb/tb_axis_dense_layer.sv - scoreboard bench for axis_dense_layer
module tb_axis_dense_layer;
  localparam int N_IN = 16, N_OUT = 16, DATA_W = 16, FRAC_W = 8, LANES = 2;
  localparam int AW = $clog2(N_OUT*N_IN+N_OUT);
  localparam int N_PARAM = N_OUT*N_IN + N_OUT;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  axis_dense_layer_if #(.DATA_W(DATA_W), .LANES(LANES)) in_r ();
  axis_dense_layer_if #(.DATA_W(DATA_W), .LANES(LANES)) out_r ();

  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic          w_ready, err_tlast, busy;

  axis_dense_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W),
                     .LANES(LANES), .RELU(0)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_r(in_r), .out_r(out_r),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ready(w_ready), .err_tlast(err_tlast), .busy(busy)
  );

  int wm [N_OUT][N_IN];
  int bm [N_OUT];
  int xs [N_IN];
  logic [32:0] exp_q [$];
  int total = 0, bad = 0;
  int cyc = 0, last_in_cyc = 0, ready_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference: exact integer sum, floor divide by 2^FRAC_W, clamp to 16-bit.
  function automatic logic [15:0] ref_y(input int o, input int nvalid);
    longint s, r;
    s = longint'(bm[o]) * 256;
    for (int i = 0; i < N_IN; i++)
      if (i < nvalid) s += longint'(xs[i]) * longint'(wm[o][i]);
    r = s >>> FRAC_W;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(posedge ap_clk) begin
    #1;
    case (ready_mode)
      0: out_r.tready = 1'b1;
      1: out_r.tready = ~out_r.tready;
      2: out_r.tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake.
  logic        prev_stall = 1'b0, prev_valid = 1'b0;
  logic [32:0] prev_beat, e;
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (out_r.tvalid) begin
        chk("in_ready_low_during_drain", in_r.tready, 0);
        if (!prev_valid) chk("first_valid_latency", cyc - last_in_cyc, N_IN + 1);
        if (prev_stall) chk("stall_hold", {out_r.tlast, out_r.tdata}, prev_beat);
        if (out_r.tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_beat", {out_r.tlast, out_r.tdata}, e);
          end
        end
        prev_stall = !out_r.tready;
        prev_beat  = {out_r.tlast, out_r.tdata};
      end else begin
        prev_stall = 1'b0;
      end
      prev_valid = out_r.tvalid;
    end
  end

  task automatic wr(input int addr, input int val, input logic expect_ok);
    w_en = 1'b1; w_addr = addr[AW-1:0]; w_data = val[15:0];
    @(negedge ap_clk);
    chk("w_ready", w_ready, expect_ok);
    if (expect_ok && addr < N_PARAM) begin
      if (addr < N_OUT*N_IN) wm[addr / N_IN][addr % N_IN] = s16(val);
      else bm[addr - N_OUT*N_IN] = s16(val);
    end
    @(posedge ap_clk); #1;
    w_en = 1'b0;
  endtask

  task automatic load_weights(input int mode, input int span);
    int o, i, v;
    for (int a = 0; a < N_PARAM; a++) begin
      o = a / N_IN; i = a % N_IN;
      case (mode)
        0: v = (a < N_OUT*N_IN && o == i) ? 256 : 0;
        1: v = 32767;
        2: v = (a < N_OUT*N_IN) ? -256 : 0;
        3: v = int'($urandom_range(0, 2*span - 1)) - span;
        default: v = (a < N_OUT*N_IN) ? 256 : 0;
      endcase
      wr(a, v, 1'b1);
    end
  endtask

  task automatic send_frame(input int tlast_at, input int nbeats);
    logic [15:0] l0, l1;
    int t;
    for (int j = 0; j < N_OUT/LANES; j++)
      exp_q.push_back({(j == N_OUT/LANES - 1), ref_y(2*j+1, nbeats*LANES), ref_y(2*j, nbeats*LANES)});
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_r.tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge ap_clk);
        #1;
      end
      l0 = xs[2*b][15:0]; l1 = xs[2*b+1][15:0];
      in_r.tvalid = 1'b1; in_r.tdata = {l1, l0}; in_r.tlast = (b == tlast_at);
      t = 0;
      @(negedge ap_clk);
      while (!in_r.tready && t < 200) begin @(negedge ap_clk); t++; end
      if (!in_r.tready) chk("in_ready_timeout", 0, 1);
      @(posedge ap_clk); #1;
      if (b == 0 && nbeats > 1) chk("busy_mid_frame", busy, 1);
      if (b == nbeats - 1) last_in_cyc = cyc;
    end
    in_r.tvalid = 1'b0; in_r.tlast = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge ap_clk); t++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge ap_clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_r.tready, 1);
    chk("idle_out_valid", out_r.tvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    in_r.tvalid = 0; in_r.tdata = 0; in_r.tlast = 0; out_r.tready = 1;
    w_en = 0; w_addr = 0; w_data = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", in_r.tready, 0);
    chk("rst_out_valid", out_r.tvalid, 0);
    chk("rst_out_last", out_r.tlast, 0);
    chk("rst_out_data", out_r.tdata, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_busy", busy, 0);
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("in_ready_after_release", in_r.tready, 1);

    // Identity weights, ramp input.
    load_weights(0, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = i * 256;
    send_frame(7, 8); wait_done();
    chk("err_clean_frame", err_tlast, 0);

    // Positive then negative saturation.
    load_weights(1, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = 32767;
    send_frame(7, 8); wait_done();
    load_weights(2, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = 'h1FFF;
    send_frame(7, 8); wait_done();

    // Identity with alternating downstream ready.
    load_weights(0, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = i * 256;
    ready_mode = 1;
    send_frame(7, 8); wait_done();

    // Random parameters and data with random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      load_weights(3, (f % 2 == 0) ? 1024 : 32768);
      for (int i = 0; i < N_IN; i++)
        xs[i] = (f % 2 == 0) ? int'($urandom_range(0, 2047)) - 1024 : int'($urandom_range(0, 65535)) - 32768;
      send_frame(7, 8); wait_done();
    end
    ready_mode = 0;
    chk("err_before_early_tlast", err_tlast, 0);

    // Early tlast on beat 3: upper half zero-filled.
    load_weights(4, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = 256;
    send_frame(3, 4); wait_done();
    chk("err_early_tlast", err_tlast, 1);
    send_frame(7, 8); wait_done();
    chk("err_sticky", err_tlast, 1);

    // Writes during COMPUTE are dropped.
    load_weights(0, 0);
    for (int i = 0; i < N_IN; i++) xs[i] = i * 256;
    send_frame(7, 8);
    wr(17, 'h4000, 1'b0);
    wr(N_OUT*N_IN + 1, 'h1000, 1'b0);
    wait_done();
    send_frame(7, 8); wait_done();

    // Reset while stalled on drain beat 3.
    ready_mode = 3;
    out_r.tready = 1'b0;
    send_frame(7, 8);
    t = 0;
    while (!out_r.tvalid && t < 100) begin @(posedge ap_clk); t++; end
    #1;
    chk("valid_before_reset", out_r.tvalid, 1);
    out_r.tready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 out_r.tready = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    chk("mid_drain_rst_valid", out_r.tvalid, 0);
    chk("mid_drain_rst_data", out_r.tdata, 0);
    chk("mid_drain_rst_err", err_tlast, 0);
    chk("mid_drain_rst_busy", busy, 0);
    chk("mid_drain_rst_ready", in_r.tready, 0);
    chk("beats_left_at_reset", exp_q.size(), 5);
    exp_q.delete();
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("in_ready_after_mid_reset", in_r.tready, 1);
    ready_mode = 0;
    send_frame(7, 8); wait_done();

    // Last beat without tlast still completes but flags an error.
    chk("err_before_missing_tlast", err_tlast, 0);
    send_frame(-1, 8); wait_done();
    chk("err_missing_tlast", err_tlast, 1);

    // Out-of-range addresses change nothing.
    wr(N_PARAM, 'h1234, 1'b1);
    wr(300, 'h7777, 1'b1);
    for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 4095)) - 2048;
    send_frame(7, 8); wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
